// File: rtl/mfu_ctrl_if.sv
// Descriptor, operand and result handshakes between a job source and mfu_ctrl.
// The slave modport is the controller's view and the master modport is the source's view.
interface mfu_ctrl_if #(
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_mode;
    logic [LEN_W-1:0] cfg_len;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             res_sat;

    modport slave (
        input  cfg_valid, cfg_mode, cfg_len, in_valid, in_a, in_b, res_ready,
        output cfg_ready, in_ready, res_valid, res_data, res_sat
    );

    modport master (
        output cfg_valid, cfg_mode, cfg_len, in_valid, in_a, in_b, res_ready,
        input  cfg_ready, in_ready, res_valid, res_data, res_sat
    );
endinterface

// File: rtl/mfu_ctrl.sv
// Job sequencer for one mFU: streams operand beats and accumulates signed products per job.
// Optional ACC_SAT_EN makes the accumulator saturate and drives a sticky res_sat flag.
module mfu_ctrl #(
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
) (
    input  logic        clk,
    input  logic        nrst,
    mfu_ctrl_if.slave   bus,
    output logic [7:0]  o_mfu_a,
    output logic [7:0]  o_mfu_b,
    output logic [1:0]  o_mfu_mode,
    input  logic [15:0] i_mfu_p,
    output logic        o_busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [1:0] MODE_NOOP = 2'b11;

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_rem;
    logic [ACC_W-1:0] r_acc;
    logic             r_sv;
    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic [1:0]       r_mode;

    logic             w_accept;
    logic             w_in_ready;
    logic             w_beat;
    logic             w_last;
    logic [ACC_W-1:0] w_p_ext;
    logic [ACC_W-1:0] w_acc_nxt;

    assign w_accept   = (r_state == S_IDLE) && bus.cfg_valid;
    assign w_in_ready = (r_state == S_RUN) && (r_rem != '0);
    assign w_beat     = w_in_ready && bus.in_valid;
    assign w_last     = w_beat && (r_rem == LEN_W'(1));
    assign w_p_ext    = ACC_W'(signed'(i_mfu_p));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.cfg_valid) r_state <= (bus.cfg_len != '0) ? S_RUN : S_DONE;
                S_RUN:   if (w_last) r_state <= S_FLUSH;
                S_FLUSH: r_state <= S_DONE;
                S_DONE:  if (bus.res_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_rem <= '0;
        end else if (w_accept) begin
            r_rem <= bus.cfg_len;
        end else if (w_beat) begin
            r_rem <= r_rem - LEN_W'(1);
        end
    end

    // Operand stage: a bubble zeroes the operands so the mFU sees a quiet bus.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_sv <= 1'b0;
            r_a  <= '0;
            r_b  <= '0;
        end else begin
            r_sv <= w_beat;
            r_a  <= w_beat ? bus.in_a : 8'h00;
            r_b  <= w_beat ? bus.in_b : 8'h00;
        end
    end

    // Mode only changes at job boundaries, so the mFU never switches mid-stream.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_mode <= MODE_NOOP;
        end else if (w_accept) begin
            r_mode <= bus.cfg_mode;
        end else if ((r_state == S_DONE) && bus.res_ready) begin
            r_mode <= MODE_NOOP;
        end
    end

`ifdef ACC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] w_sum;
    logic           w_ovf;
    logic           r_sat;

    // One guard bit: the sum overflowed when it disagrees with the result sign bit.
    assign w_sum     = {r_acc[ACC_W-1], r_acc} + {w_p_ext[ACC_W-1], w_p_ext};
    assign w_ovf     = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign w_acc_nxt = !w_ovf ? w_sum[ACC_W-1:0] : (w_sum[ACC_W] ? ACC_MIN : ACC_MAX);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_sat <= 1'b0;
        end else if (w_accept) begin
            r_sat <= 1'b0;
        end else if (r_sv && w_ovf) begin
            r_sat <= 1'b1;
        end
    end

    assign bus.res_sat = r_sat;
`else
    assign w_acc_nxt   = r_acc + w_p_ext;
    assign bus.res_sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
        end else if (r_sv) begin
            r_acc <= w_acc_nxt;
        end
    end

    assign bus.cfg_ready = (r_state == S_IDLE);
    assign bus.in_ready  = w_in_ready;
    assign bus.res_valid = (r_state == S_DONE);
    assign bus.res_data  = r_acc;

    assign o_mfu_a    = r_a;
    assign o_mfu_b    = r_b;
    assign o_mfu_mode = r_mode;
    assign o_busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_mfu_ctrl.sv
// Bench for mfu_ctrl: a job-level model checked every cycle, directed jobs with literal results,
// and a 16-bit accumulator instance for the overflow case.
module tb_mfu_ctrl;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    mfu_ctrl_if #(.ACC_W(32), .LEN_W(8)) bus ();
    mfu_ctrl_if #(.ACC_W(16), .LEN_W(8)) bus16 ();

    logic [7:0]  mfu_a, mfu_b, mfu_a16, mfu_b16;
    logic [1:0]  mfu_mode, mfu_mode16;
    logic [15:0] mfu_p, mfu_p16;
    logic        busy, busy16;

    // Reference multi-precision multiplier: sum of signed lane products.
    function automatic int prod(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        int s;
        s = 0;
        case (m)
            2'b00: s = int'($signed(a)) * int'($signed(b));
            2'b01: for (int i = 0; i < 2; i++) s += int'($signed(a[4*i+:4])) * int'($signed(b[4*i+:4]));
            2'b10: for (int i = 0; i < 4; i++) s += int'($signed(a[2*i+:2])) * int'($signed(b[2*i+:2]));
            default: s = 0;
        endcase
        return s;
    endfunction

    assign mfu_p   = 16'(prod(mfu_mode, mfu_a, mfu_b));
    assign mfu_p16 = 16'(prod(mfu_mode16, mfu_a16, mfu_b16));

    mfu_ctrl #(.ACC_W(32), .LEN_W(8)) u_dut (
        .clk(clk), .nrst(nrst), .bus(bus),
        .o_mfu_a(mfu_a), .o_mfu_b(mfu_b), .o_mfu_mode(mfu_mode),
        .i_mfu_p(mfu_p), .o_busy(busy)
    );

    mfu_ctrl #(.ACC_W(16), .LEN_W(8)) u_dut16 (
        .clk(clk), .nrst(nrst), .bus(bus16),
        .o_mfu_a(mfu_a16), .o_mfu_b(mfu_b16), .o_mfu_mode(mfu_mode16),
        .i_mfu_p(mfu_p16), .o_busy(busy16)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Job-level model: tracks descriptor, beats and result handshakes; sums products per beat.
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;
    bit         m_busy = 0, m_resv = 0, m_flush = 0, m_sat = 0;
    int         m_rem = 0;
    logic [1:0] m_mode = 2'b11;
    longint     m_sum = 0;
    logic [7:0] m_a = 0, m_b = 0;

    always @(posedge clk) begin : mdl
        longint     s;
        bit         st;
        logic [7:0] na, nb;
        na = 8'h00;
        nb = 8'h00;
        if (!nrst) begin
            m_busy <= 0; m_resv <= 0; m_flush <= 0; m_sat <= 0;
            m_rem <= 0; m_mode <= 2'b11; m_sum <= 0;
        end else if (!m_busy) begin
            if (bus.cfg_valid) begin
                m_busy <= 1; m_mode <= bus.cfg_mode; m_rem <= int'(bus.cfg_len);
                m_sum <= 0; m_sat <= 0; m_resv <= (bus.cfg_len == 8'd0);
            end
        end else if (m_resv) begin
            if (bus.res_ready) begin
                m_busy <= 0; m_resv <= 0; m_mode <= 2'b11;
            end
        end else if (m_rem > 0) begin
            if (bus.in_valid) begin
                s  = m_sum + longint'(prod(m_mode, bus.in_a, bus.in_b));
                st = m_sat;
`ifdef ACC_SAT_EN
                if (s > MAXV) begin s = MAXV; st = 1; end
                else if (s < MINV) begin s = MINV; st = 1; end
`endif
                m_sum <= s; m_sat <= st; m_rem <= m_rem - 1;
                na = bus.in_a; nb = bus.in_b;
                if (m_rem == 1) m_flush <= 1;
            end
        end else if (m_flush) begin
            m_flush <= 0; m_resv <= 1;
        end
        m_a <= na;
        m_b <= nb;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",      64'(busy),           64'(m_busy));
            chk("cfg_ready", 64'(bus.cfg_ready),  64'(!m_busy));
            chk("in_ready",  64'(bus.in_ready),   64'(m_busy && !m_resv && (m_rem > 0)));
            chk("res_valid", 64'(bus.res_valid),  64'(m_resv));
            chk("mfu_mode",  64'(mfu_mode),       64'(m_mode));
            chk("mfu_a",     64'(mfu_a),          64'(m_a));
            chk("mfu_b",     64'(mfu_b),          64'(m_b));
            if (m_resv) begin
                chk("res_data", 64'(bus.res_data), 64'(m_sum) & 64'hFFFF_FFFF);
                chk("res_sat",  64'(bus.res_sat),  64'(m_sat));
            end
        end
    end

    task automatic start_job(input logic [1:0] m, input int len);
        int k;
        k = 0;
        while (!bus.cfg_ready && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) chk("cfg_wait_timeout", 64'd1, 64'd0);
        bus.cfg_valid = 1'b1; bus.cfg_mode = m; bus.cfg_len = 8'(len);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_res(input string nm);
        int k;
        k = 0;
        while (!bus.res_valid && k < 20) begin @(negedge clk); k++; end
        if (k >= 20) chk({nm, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic take_res(input string nm, input logic [31:0] exp);
        wait_res(nm);
        chk(nm, 64'(bus.res_data), 64'(exp));
        chk({nm, "_model"}, 64'(m_sum) & 64'hFFFF_FFFF, 64'(exp));
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.cfg_valid = 0; bus.cfg_mode = 0; bus.cfg_len = 0; bus.in_valid = 0;
        bus.in_a = 0; bus.in_b = 0; bus.res_ready = 0;
        bus16.cfg_valid = 0; bus16.cfg_mode = 0; bus16.cfg_len = 0; bus16.in_valid = 0;
        bus16.in_a = 0; bus16.in_b = 0; bus16.res_ready = 0;
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        chk_en = 1'b1;
        chk("rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
        chk("rst_busy",      64'(busy),          64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_data",  64'(bus.res_data),  64'd0);
        chk("rst_mfu_mode",  64'(mfu_mode),      64'd3);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);

        // 8x8, three back-to-back beats, result two cycles after the last beat
        start_job(2'b00, 3);
        beat(8'd3, 8'd4);
        chk("t1_mode_run", 64'(mfu_mode), 64'd0);
        beat(8'd3, 8'd4);
        beat(8'd3, 8'd4);
        chk("t1_not_yet", 64'(bus.res_valid), 64'd0);
        @(negedge clk);
        chk("t1_lat2", 64'(bus.res_valid), 64'd1);
        take_res("t1_data", 32'd36);
        chk("t1_mode_idle", 64'(mfu_mode), 64'd3);

        // signed 8x8, then 4x4 nibble mode
        start_job(2'b00, 1);
        beat(8'hFB, 8'h07);
        take_res("t2_neg", 32'hFFFF_FFDD);
        start_job(2'b01, 1);
        beat(8'h21, 8'h31);
        take_res("t2_4x4", 32'd7);

        // gapped beats and a 5-cycle result stall with a stray descriptor
        start_job(2'b00, 4);
        beat(8'd1, 8'd1); @(negedge clk);
        beat(8'd1, 8'd1); @(negedge clk);
        beat(8'd1, 8'd1); @(negedge clk);
        beat(8'd1, 8'd1);
        wait_res("t3");
        bus.cfg_valid = 1'b1; bus.cfg_mode = 2'b00; bus.cfg_len = 8'd9;
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_data", 64'(bus.res_data), 64'd4);
            chk("t3_cfg_ready",  64'(bus.cfg_ready), 64'd0);
            @(negedge clk);
        end
        bus.cfg_valid = 1'b0;
        take_res("t3_data", 32'd4);
        chk("t3_cfg_after", 64'(bus.cfg_ready), 64'd1);

        // zero-length job and NOOP mode job
        start_job(2'b00, 0);
        chk("t4_len0_valid", 64'(bus.res_valid), 64'd1);
        take_res("t4_len0", 32'd0);
        start_job(2'b11, 2);
        beat(8'h7F, 8'h7F);
        beat(8'h7F, 8'h7F);
        take_res("t4_noop", 32'd0);

        // reset after 2 of 5 beats; beats during reset/IDLE are ignored
        start_job(2'b00, 5);
        beat(8'd1, 8'd2);
        beat(8'd1, 8'd2);
        nrst = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("t5_busy",      64'(busy),          64'd0);
        chk("t5_mode",      64'(mfu_mode),      64'd3);
        chk("t5_res_valid", 64'(bus.res_valid), 64'd0);
        chk("t5_res_data",  64'(bus.res_data),  64'd0);
        chk("t5_mfu_a",     64'(mfu_a),         64'd0);
        chk("t5_cfg_ready", 64'(bus.cfg_ready), 64'd1);
        nrst = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t5_idle_valid", 64'(bus.res_valid), 64'd0);
        start_job(2'b10, 2);
        beat(8'h5B, 8'h77);
        beat(8'h5B, 8'h77);
        take_res("t5_2x2", 32'hFFFF_FFFE);

        // 16-bit accumulator: 16384 + 16384 overflows
        bus16.cfg_valid = 1'b1; bus16.cfg_mode = 2'b00; bus16.cfg_len = 8'd2;
        @(negedge clk);
        bus16.cfg_valid = 1'b0;
        bus16.in_valid = 1'b1; bus16.in_a = 8'h80; bus16.in_b = 8'h80;
        @(negedge clk);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        chk("t6_not_yet", 64'(bus16.res_valid), 64'd0);
        @(negedge clk);
        chk("t6_valid", 64'(bus16.res_valid), 64'd1);
`ifdef ACC_SAT_EN
        chk("t6_data", 64'(bus16.res_data), 64'h7FFF);
        chk("t6_sat",  64'(bus16.res_sat),  64'd1);
`else
        chk("t6_data", 64'(bus16.res_data), 64'h8000);
        chk("t6_sat",  64'(bus16.res_sat),  64'd0);
`endif
        bus16.res_ready = 1'b1;
        @(negedge clk);
        bus16.res_ready = 1'b0;
        chk("t6_idle", 64'(busy16), 64'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mfu_ctrl.md
# mfu_ctrl

Job sequencer for one multi-precision multiply unit (mFU) in the systolic array. It accepts a job descriptor (precision mode, beat count), streams operand pairs into the mFU, and accumulates the signed 16-bit mFU product into a wide accumulator. It returns one result per job over a valid/ready handshake. While idle it parks the mFU in NOOP mode, so mode changes only ever happen between jobs.

## Interface
- ACC_W, 32: accumulator and result width in bits; legal range 16 to 48.
- LEN_W, 8: width of the job beat count.

- clk  in  1  clock.
- nrst  in  1  reset: synchronous, active-low.
- cfg_valid  in  1  job descriptor valid.
- cfg_ready  out  1  descriptor accepted; high only in IDLE.
- cfg_mode  in  2  mFU mode: 00 8x8, 01 4x4, 10 2x2, 11 NOOP.
- cfg_len  in  LEN_W  number of operand beats; 0 is legal.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  beat accepted; high in RUN while beats remain.
- in_a, in_b  in  8  operand pair.
- mfu_a, mfu_b  out  8  registered operands to the mFU.
- mfu_mode  out  2  registered mode to the mFU.
- mfu_p  in  16  combinational mFU product, signed.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_data  out  ACC_W  accumulated signed sum.
- res_sat  out  1  sticky saturation flag for the job.
- busy  out  1  high in any state other than IDLE.

## Operation
- The FSM has four states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - cfg_ready=1 and mfu_mode=11.
  - On cfg_valid, latch cfg_mode, load the remaining-beat counter with cfg_len, clear the accumulator and res_sat.
  - Go to RUN if cfg_len!=0, else go to DONE.
- RUN:
  - in_ready = (remaining != 0).
  - On each in_valid && in_ready: register in_a/in_b into mfu_a/mfu_b, set stage valid sv=1, decrement remaining.
  - If no beat is accepted, sv=0. mfu_a/mfu_b are zeroed on a bubble.
  - When the final beat is accepted, go to FLUSH.
- Accumulate stage, every cycle: if sv=1, acc += sign_extend(mfu_p) to ACC_W.
- FLUSH: lasts one cycle, during which the final product is accumulated. Then go to DONE.
- DONE:
  - res_valid=1; res_data and res_sat are held stable.
  - On res_ready, go to IDLE.
  - cfg_ready=0 throughout DONE, so a new descriptor can be accepted no earlier than the cycle after the result handshake.
- mfu_mode is set to the latched mode from RUN entry until DONE is left. It returns to 11 in IDLE.
- cfg_mode=11 is legal. Products are zero, so res_data=0.
- Inputs outside a handshake are ignored: in_valid in IDLE or DONE, and cfg_valid outside IDLE.

## Timing
- Reset (nrst=0 at a clk edge) forces:
  - state IDLE, counter 0, acc 0, sv=0;
  - mfu_a=mfu_b=0, mfu_mode=11;
  - res_valid=0, res_data=0, res_sat=0, busy=0, in_ready=0, cfg_ready=1 (IDLE).
- Reset mid-job discards the job; no result is produced.
- Descriptor accepted at edge t: busy=1 from t+1. RUN starts at t+1; DONE starts at t+1 if cfg_len=0.
- Beat accepted at edge t: mfu_a/mfu_b drive it during cycle t+1; it is accumulated at edge t+2.
- Last beat accepted at edge t: res_valid is first high in the cycle after edge t+2. Latency is 2 cycles from the last beat to the result.
- Full-rate streaming is 1 beat/cycle. Gaps on in_valid insert bubbles with no accumulation.
- res_valid stays high until res_ready. Holding res_ready low stalls the block indefinitely and does not corrupt the result.

## Configuration
- ACC_SAT_EN defined:
  - The accumulation saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - res_sat is set when any add clamps and stays set until the next job is accepted.
- ACC_SAT_EN undefined:
  - The accumulation wraps modulo 2^ACC_W.
  - res_sat is tied to 0.

## Test plan
- 8x8 job, cfg_len=3, three beats a=3, b=4 back-to-back. Required: res_data=36; res_valid high 2 cycles after the last beat; mfu_mode=00 during the job and 11 afterwards.
- 8x8 job, cfg_len=1, a=0xFB (-5), b=0x07. Required: res_data=0xFFFFFFDD (-35). A second job, 4x4, a=0x21, b=0x31, yields 7 (2*3 + 1*1).
- Backpressure: 4 beats of a=1, b=1 with in_valid toggling 1-0-1-0, and res_ready held low 5 cycles. Required: res_data=4 stable throughout the stall; cfg_ready=0 until the cycle after the handshake.
- cfg_len=0: res_valid rises the cycle after cfg acceptance with res_data=0. Same result for any cfg_len when cfg_mode=11.
- ACC_W=16, 8x8 mode, 2 beats a=b=0x80 (16384 each). Required: 32767 with res_sat=1 when ACC_SAT_EN is defined; 0x8000 with res_sat=0 when undefined.
- Reset asserted in RUN after 2 of 5 beats. Required: all outputs at their reset values the next cycle, mfu_mode=11, no result. A new job then completes correctly.
